// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : Serial-to-parallel UART receiver. 8 data bits LSB first,
//            optional odd/even parity, one stop bit, mid-bit sampling.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,            // asynchronous, active-low
  input  logic       serial_in,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_error,
  output logic       framing_error,
  output logic       busy
);

  localparam int            CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  state_e        state_q,  state_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q,  shift_d;
  logic [1:0]    ptype_q,  ptype_d;
  logic          pfail_q,  pfail_d;
  logic          armed_q,  armed_d;
  logic [7:0]    data_q,   data_d;
  logic          dv_q,     dv_d;
  logic          perr_q,   perr_d;
  logic          ferr_q,   ferr_d;

  // Synchroniser chain; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], serial_in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // State, counters, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      ptype_q   <= '0;
      pfail_q   <= 1'b0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      dv_q      <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      ptype_q   <= ptype_d;
      pfail_q   <= pfail_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // Next-state logic: bit timing, sampling and frame completion.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    ptype_d   = ptype_q;
    pfail_d   = pfail_q;
    armed_d   = armed_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        // Only a high-to-low transition seen after an idle-high period
        // starts a frame, so a held break never retriggers reception.
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == C_HALF) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;          // glitch, not a real start bit
          end else begin
            state_d = S_DATA;
            ptype_d = parity_type;     // held for the whole frame
            pfail_d = 1'b0;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == C_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = (ptype_q == 2'd1 || ptype_q == 2'd2) ? S_PARITY : S_STOP;
          end
        end
      end

      S_PARITY: begin
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          state_d = S_STOP;
          // Even parity expects XOR of data; odd expects its inverse.
          pfail_d = rx_s ^ ((ptype_q == 2'd2) ? (^shift_q) : ~(^shift_q));
        end
      end

      S_STOP: begin
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          dv_d    = 1'b1;
          data_d  = shift_q;
          perr_d  = pfail_q;
          ferr_d  = ~rx_s;
          if (!rx_s) begin
            armed_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign data_out      = data_q;
  assign data_valid    = dv_q;
  assign parity_error  = perr_q;
  assign framing_error = ferr_q;
  assign busy          = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver. It is the receive end of the team's UART link and pairs with the transmitter block.
- Frame format: 1 start bit (low), 8 data bits LSB first, optional parity bit, 1 stop bit (high). Line idles high.
- It synchronises the asynchronous serial line, samples each bit at mid-bit, and presents the received byte with a one-cycle valid strobe and error flags.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud); must be >= 4
SYNC_STAGES, 2, flip-flops in the serial_in synchroniser; must be >= 2

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
serial_in  input  1  asynchronous serial line, idle high
parity_type  input  2  0 none, 1 odd, 2 even, 3 none
data_out  output  8  last received byte
data_valid  output  1  one-cycle strobe: data_out and error flags updated
parity_error  output  1  parity mismatch on last frame
framing_error  output  1  stop bit sampled low on last frame
busy  output  1  high while a frame is being received (any state but IDLE)

Behaviour:
- Reset: rst low asynchronously forces all of the following:
  - state IDLE; all counters 0
  - synchroniser flops set to 1
  - data_out=8'h00; data_valid, parity_error, framing_error and busy all 0
- Reset mid-frame aborts the frame. No data_valid is produced for it.
- Synchroniser: serial_in passes through SYNC_STAGES flops. All sampling uses the synchronised signal rx_s.
- Bit counter: runs 0..CLKS_PER_BIT-1 in each timed state and clears on every state change.
- States:
  - IDLE: when rx_s=0 and armed=1, go to START with the counter cleared. armed is set whenever rx_s=1 is seen in IDLE and is cleared on a framing error. A line held low (break) therefore never restarts reception.
  - START: at count CLKS_PER_BIT/2-1 (integer division), sample rx_s.
    - rx_s=1 → glitch; return to IDLE with no flags changed.
    - rx_s=0 → go to DATA with counter 0. From this point the sample points are mid-bit.
    - parity_type is latched at this transition and held for the whole frame.
  - DATA: at count CLKS_PER_BIT-1, shift rx_s into shift_reg[7] (right shift, LSB first) and increment bit_idx.
    - After the 8th sample, go to PARITY if the latched parity_type is 1 or 2, otherwise go to STOP.
  - PARITY: at count CLKS_PER_BIT-1, sample the parity bit, then go to STOP.
    - Expected bit: even → XOR of the 8 data bits; odd → its inverse.
  - STOP: at count CLKS_PER_BIT-1, sample rx_s and go to IDLE.
    - On the next cycle, data_valid=1 for exactly one cycle.
    - On that same cycle, data_out takes shift_reg, parity_error takes the mismatch result (0 if no parity), and framing_error takes (stop sample==0).
- data_out and the error flags hold until the next data_valid. They are not cleared by a later glitch or an aborted frame.
- Each frame resynchronises on its own start edge, so back-to-back frames (next start immediately after stop) are received without loss.
- Latency: data_valid rises SYNC_STAGES+1 cycles after the stop-bit mid-sample point on serial_in, to within ±1 cycle of edge-alignment uncertainty.
- Frame with errors: data_out is still updated and data_valid still pulses; the flags qualify the byte.
- parity_type changes mid-frame have no effect until the next frame.

Test Plan:
(all scenarios use CLKS_PER_BIT=16, 20 ns clk)
1. Reset: rst=0 with serial_in toggling → all outputs 0 and busy=0. After release with the line idle high, outputs stay 0.
2. No parity: send 0xD2 (parity_type=0), stop=1 → one data_valid pulse, data_out=8'hD2, parity_error=0, framing_error=0; busy returns to 0.
3. Even parity: send 0xD2 with parity_type=2 and parity bit 0 → data_out=D2, parity_error=0. Repeat with parity bit 1 → parity_error=1, data_valid still pulses once.
4. Odd parity plus back-to-back frames: 0x55 with parity 1, then 0xA5 with parity 1 and no idle gap → two pulses. data_out=55 with parity_error=0, then data_out=A5 with parity_error=0.
5. Glitch rejection: 5-cycle low pulse on an idle line → no data_valid, busy returns to 0, previous data_out unchanged.
6. Errors and reset abort:
   - Send 0x3C with the stop bit low, then hold the line low for 3 bit times → framing_error=1, data_out=3C, no second frame. A normal 0x81 frame after the line returns high → data_out=81, framing_error=0.
   - Assert rst during bit 4 of a frame → no data_valid, all outputs 0.
